// File: rtl/bitfusion_pkg.sv
// Shared types and helpers for the bitfusion column job sequencer.
package bitfusion_pkg;

  localparam int COL_WIDTH_DEF = 13;
  localparam int LANES         = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_DRAIN,
    ST_DONE
  } state_e;

  // Precision configuration presented to the fusion unit for one job.
  typedef struct packed {
    logic [3:0] in_width;
    logic [3:0] weight_width;
    logic       s_in;
    logic       s_weight;
  } fu_cfg_t;

  function automatic logic width_legal(input logic [3:0] w);
    return (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

endpackage

// File: rtl/bitfusion_acc.sv
// Four-lane wrap-around accumulator; lanes are independent, carries never
// cross a lane boundary.
module bitfusion_acc
  import bitfusion_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       add_en,
  input  logic [COL_WIDTH*LANES-1:0] add_data,
  output logic [COL_WIDTH*LANES-1:0] acc
);

  logic [COL_WIDTH*LANES-1:0] acc_d, acc_q;

  always_comb begin
    // NOTE: assign a default first so every path drives acc_d and no latch is inferred.
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (add_en) begin
      for (int l = 0; l < LANES; l++) begin
        acc_d[l*COL_WIDTH +: COL_WIDTH] =
          acc_q[l*COL_WIDTH +: COL_WIDTH] + add_data[l*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

  assign acc = acc_q;

endmodule

// File: rtl/bitfusion_seq.sv
// Job sequencer for one bitfusion_top column: issues buffer reads, tracks the
// fusion-unit latency, accumulates psum_fwd and returns one 4-lane result per job.
module bitfusion_seq
  import bitfusion_pkg::*;
#(
  parameter int COL_WIDTH = COL_WIDTH_DEF,
  parameter int ADDR_W    = 8,
  parameter int FU_LAT    = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [ADDR_W-1:0]          cfg_len,
  input  logic [ADDR_W-1:0]          cfg_in_base,
  input  logic [ADDR_W-1:0]          cfg_wt_base,
  input  logic [3:0]                 cfg_in_width,
  input  logic [3:0]                 cfg_weight_width,
  input  logic                       cfg_s_in,
  input  logic                       cfg_s_weight,
  input  logic [COL_WIDTH*LANES-1:0] cfg_bias,
  output logic                       rd_en,
  output logic [ADDR_W-1:0]          in_addr,
  output logic [ADDR_W-1:0]          wt_addr,
  output logic [3:0]                 fu_in_width,
  output logic [3:0]                 fu_weight_width,
  output logic                       fu_s_in,
  output logic                       fu_s_weight,
  output logic [COL_WIDTH*LANES-1:0] fu_psum_in,
  input  logic [COL_WIDTH*LANES-1:0] fu_psum_fwd,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [COL_WIDTH*LANES-1:0] res_data,
  output logic                       res_err
);

  localparam int PW = COL_WIDTH * LANES;

  state_e            state_q, state_d;
  logic              cfg_ready_q, cfg_ready_d;
  logic              rd_en_q, rd_en_d;
  logic              rd_first_q, rd_first_d;
  logic [ADDR_W-1:0] in_addr_q, in_addr_d;
  logic [ADDR_W-1:0] wt_addr_q, wt_addr_d;
  logic [ADDR_W-1:0] remain_q, remain_d;
  fu_cfg_t           fu_cfg_q, fu_cfg_d;
  logic [PW-1:0]     bias_q, bias_d;
  logic [FU_LAT:0]   vld_q, vld_d;
  logic              first_q, first_d;
  logic              res_valid_q, res_valid_d;
  logic              res_err_q, res_err_d;
  logic              acc_clr;
  logic              cfg_legal;

  assign cfg_legal = width_legal(cfg_in_width) && width_legal(cfg_weight_width);

  always_comb begin
    state_d     = state_q;
    cfg_ready_d = cfg_ready_q;
    rd_en_d     = rd_en_q;
    rd_first_d  = rd_first_q;
    in_addr_d   = in_addr_q;
    wt_addr_d   = wt_addr_q;
    remain_d    = remain_q;
    fu_cfg_d    = fu_cfg_q;
    bias_d      = bias_q;
    res_valid_d = res_valid_q;
    res_err_d   = res_err_q;
    acc_clr     = 1'b0;

    // Stage 0 lines up with read data at the fusion-unit inputs; stage FU_LAT
    // lines up with the matching psum_fwd.
    vld_d[0] = rd_en_q;
    first_d  = rd_en_q && rd_first_q;
    for (int k = 1; k <= FU_LAT; k++) begin
      vld_d[k] = vld_q[k-1];
    end

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          acc_clr     = 1'b1;
          cfg_ready_d = 1'b0;
          res_err_d   = 1'b0;
          if (!cfg_legal) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
            res_err_d   = 1'b1;
          end else if (cfg_len == '0) begin
            state_d     = ST_DONE;
            res_valid_d = 1'b1;
          end else begin
            state_d   = ST_ISSUE;
            rd_en_d   = 1'b1;
            rd_first_d = 1'b1;
            in_addr_d = cfg_in_base;
            wt_addr_d = cfg_wt_base;
            remain_d  = cfg_len - ADDR_W'(1);
            fu_cfg_d  = '{in_width:     cfg_in_width,
                          weight_width: cfg_weight_width,
                          s_in:         cfg_s_in,
                          s_weight:     cfg_s_weight};
            bias_d    = cfg_bias;
          end
        end
      end
      ST_ISSUE: begin
        rd_first_d = 1'b0;
        if (remain_q == '0) begin
          rd_en_d = 1'b0;
          state_d = ST_DRAIN;
        end else begin
          in_addr_d = in_addr_q + ADDR_W'(1);
          wt_addr_d = wt_addr_q + ADDR_W'(1);
          remain_d  = remain_q - ADDR_W'(1);
        end
      end
      ST_DRAIN: begin
        // Leave on the edge that consumes the last in-flight element.
        if (vld_d == '0) begin
          state_d     = ST_DONE;
          res_valid_d = 1'b1;
        end
      end
      ST_DONE: begin
        if (res_ready) begin
          state_d     = ST_IDLE;
          res_valid_d = 1'b0;
          cfg_ready_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cfg_ready_q <= 1'b1;
      rd_en_q     <= 1'b0;
      rd_first_q  <= 1'b0;
      in_addr_q   <= '0;
      wt_addr_q   <= '0;
      remain_q    <= '0;
      fu_cfg_q    <= '0;
      bias_q      <= '0;
      vld_q       <= '0;
      first_q     <= 1'b0;
      res_valid_q <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_ready_q <= cfg_ready_d;
      rd_en_q     <= rd_en_d;
      rd_first_q  <= rd_first_d;
      in_addr_q   <= in_addr_d;
      wt_addr_q   <= wt_addr_d;
      remain_q    <= remain_d;
      fu_cfg_q    <= fu_cfg_d;
      bias_q      <= bias_d;
      vld_q       <= vld_d;
      first_q     <= first_d;
      res_valid_q <= res_valid_d;
      res_err_q   <= res_err_d;
    end
  end

  bitfusion_acc #(
    .COL_WIDTH (COL_WIDTH)
  ) u_acc (
    .clk      (clk),
    .rst      (rst),
    .clr      (acc_clr),
    .add_en   (vld_q[FU_LAT]),
    .add_data (fu_psum_fwd),
    .acc      (res_data)
  );

  assign cfg_ready       = cfg_ready_q;
  assign rd_en           = rd_en_q;
  assign in_addr         = in_addr_q;
  assign wt_addr         = wt_addr_q;
  assign fu_in_width     = fu_cfg_q.in_width;
  assign fu_weight_width = fu_cfg_q.weight_width;
  assign fu_s_in         = fu_cfg_q.s_in;
  assign fu_s_weight     = fu_cfg_q.s_weight;
  assign fu_psum_in      = first_q ? bias_q : '0;
  assign res_valid       = res_valid_q;
  assign res_err         = res_err_q;

endmodule

// File: doc/bitfusion_seq.md
# bitfusion_seq

Job sequencer for one `bitfusion_top` column.
- Accepts a dot-product job descriptor: buffer base addresses, length, operand widths and signedness.
- Streams addresses to the input and weight buffers one element per cycle, and holds the fusion unit's precision configuration stable.
- Tracks the fixed pipeline latency, accumulates `psum_fwd` lane-wise, and returns one 4-lane result per job over a valid/ready handshake.
- Sits between the layer-level scheduler and the buffer/fusion-unit datapath.

## Interface
Parameters:
- `COL_WIDTH`, 13, width of one psum lane (result is 4 lanes)
- `ADDR_W`, 8, buffer address width; also job-length width
- `FU_LAT`, 2, cycles from a `bitfusion_top` input change to the corresponding `psum_fwd`

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `cfg_valid`  in  1  job descriptor valid
- `cfg_ready`  out  1  high only in IDLE
- `cfg_len`  in  ADDR_W  element count N; 0 is legal
- `cfg_in_base`, `cfg_wt_base`  in  ADDR_W  first buffer addresses
- `cfg_in_width`, `cfg_weight_width`  in  4  operand bits; legal values 2, 4, 8
- `cfg_s_in`, `cfg_s_weight`  in  1  signed flags
- `cfg_bias`  in  COL_WIDTH*4  psum seed applied with element 0
- `rd_en`  out  1  buffer read strobe; read data appears at `bitfusion_top` inputs the next cycle
- `in_addr`, `wt_addr`  out  ADDR_W  buffer addresses
- `fu_in_width`, `fu_weight_width`  out  4  driven from latched config
- `fu_s_in`, `fu_s_weight`  out  1  driven from latched config
- `fu_psum_in`  out  COL_WIDTH*4  bias or 0, aligned with data
- `fu_psum_fwd`  in  COL_WIDTH*4  fusion unit result
- `res_valid`  out  1  result available
- `res_ready`  in  1  consumer accepts
- `res_data`  out  COL_WIDTH*4  accumulated lanes
- `res_err`  out  1  job rejected (illegal width)

## Operation
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- **IDLE:**
  - `cfg_ready`=1.
  - On a `cfg_valid` handshake: latch the descriptor and clear the accumulator.
  - Illegal width → DONE with `res_err`=1 and `res_data`=0. No reads are issued.
  - N=0 → DONE with `res_data`=0 and `res_err`=0.
  - Otherwise → ISSUE.
- **ISSUE:**
  - `rd_en`=1 for exactly N consecutive cycles; addresses start at the bases and increment by 1 per cycle, wrapping modulo 2^ADDR_W.
  - After the Nth read → DRAIN.
- **Valid tracking:** a shift register of depth 1+FU_LAT carries each read's valid bit and a first-element flag.
  - `fu_psum_in` = latched bias in the cycle element 0's data is at the fusion unit inputs (`rd_en` delayed 1); 0 otherwise.
- **Accumulation:** when a valid emerges from the shift register, add `fu_psum_fwd` into the accumulator.
  - Lane-wise, each lane COL_WIDTH bits, wrapping modulo 2^COL_WIDTH, no carry between lanes.
- **DRAIN:** wait until the shift register is empty → DONE.
- **DONE:**
  - `res_valid`=1; `res_data` and `res_err` are held stable.
  - On a `res_valid`&&`res_ready` handshake → IDLE.
- **Held outputs:** `fu_*` config outputs hold their last job's values outside ISSUE/DRAIN.
- **Outside ISSUE:** `cfg_valid` is ignored while busy; `rd_en`=0.

## Timing
- **Reset values:** all outputs 0, state IDLE, except `cfg_ready`=1.
- **Reset mid-job:** asserting `rst` at any point aborts the job; the valid pipeline and accumulator are cleared, and no stale result follows.
- **Job timing**, with the `cfg` handshake at edge E:
  - `rd_en` is high in cycles E+1..E+N.
  - The accumulate for element i occurs at edge E+i+2+FU_LAT.
  - `res_valid` rises in cycle E+N+2+FU_LAT.
  - Default FU_LAT=2, N=4: `res_valid` in cycle E+8.
- **Illegal width or N=0:** `res_valid` in cycle E+1.
- **Back-to-back jobs:** `cfg_ready` returns in the cycle after the result handshake, so there is no overlap between jobs.
- **Result stalls:** `res_ready` low holds DONE indefinitely, with outputs stable.

## Structure
- Package `bitfusion_pkg` holds:
  - `COL_WIDTH` default
  - FSM state enum
  - function `width_legal(w)` → 1 for 2, 4, 8
  - lane count constant (4)
- Sub-module `bitfusion_acc`: the 4-lane COL_WIDTH wrap-around accumulator with clear and add-enable.
- FSM, counters and valid shift register stay in `bitfusion_seq`.

## Test plan
- N=4, bases 0x10/0x20, widths 8/8, bias 0, model `fu_psum_fwd` each lane = 1 → `rd_en` cycles E+1..E+4, addresses 0x10..0x13 and 0x20..0x23; `res_data` lanes all 4 at cycle E+8.
- N=3, bias lane0 = 5 → `fu_psum_in`=bias only in cycle E+2, 0 in E+3 and E+4.
- Accumulate overflow: N=2, lane psum 0x1000 each at COL_WIDTH=13 → lane = 0x0000; no carry into the neighbouring lane.
- `cfg_in_width`=3 → no `rd_en`; `res_valid`, `res_err`=1 at E+1. `cfg_len`=0 → `res_data`=0, `res_err`=0 at E+1.
- Base 0xFE, N=4 → addresses FE, FF, 00, 01. Hold `res_ready`=0 for 5 cycles → result stable and `cfg_ready`=0 throughout.
- Assert `rst` in cycle E+3 of an N=8 job → all outputs at reset values immediately; next job's result is uncontaminated.
